// File: rtl/afe_chan_sequencer.sv
// afe_chan_sequencer
//   Scan controller for a multi-channel analog front end. Channels are visited
//   round-robin. For each channel the sequencer:
//     - enables that channel's OTA and points the shared output mux at it;
//     - waits a programmable settle time;
//     - samples the synchronised comparator NSAMP times;
//     - offers the majority decision downstream.
//
// Optional feature (macro): AFE_CHAN_MASK_EN
//   When defined, the chan_mask port exists and only channels with
//   chan_mask[i]=1 are eligible for scanning. When undefined, every channel
//   is scanned.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active-high
//   scan_en        level request for continuous round-robin scanning
//   settle_cycles  settle wait per channel (0 is treated as 1), captured on
//                  entry to SETTLE
//   cmp_in         asynchronous comparator output (synchronised internally)
//   chan_mask      channel enable mask (AFE_CHAN_MASK_EN only)
//   amp_en         one-hot OTA enable of the active channel, zero when idle
//   mux_sel        analog mux select (active channel index)
//   busy           high whenever the sequencer is not idle
//   res_valid      result valid
//   res_ready      downstream ready
//   res_chan       channel that produced the result
//   res_bit        majority decision
//   res_count      number of samples that read 1
//   state_dbg      current FSM state, for observation only
//
// Result handshake: a transfer happens on every rising clk edge where
// res_valid && res_ready. Once res_valid is high, it stays high and
// res_chan/res_bit/res_count stay constant until that transfer. res_ready is
// allowed to be high already in the first cycle of res_valid.

module afe_chan_sequencer #(
    parameter int NCH      = 4,
    parameter int CH_W     = $clog2(NCH),
    parameter int SETTLE_W = 8,
    parameter int NSAMP    = 5,
    parameter int CNT_W    = $clog2(NSAMP + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_en,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic                cmp_in,
`ifdef AFE_CHAN_MASK_EN
    input  logic [NCH-1:0]      chan_mask,
`endif
    output logic [NCH-1:0]      amp_en,
    output logic [CH_W-1:0]     mux_sel,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CH_W-1:0]     res_chan,
    output logic                res_bit,
    output logic [CNT_W-1:0]    res_count,
    output logic [2:0]          state_dbg
);

    localparam int SUM_W = CH_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_NEXT   = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nx;

    logic [CH_W-1:0]     ch;
    logic [CH_W-1:0]     ch_ptr;
    logic [CH_W-1:0]     ch_inc;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [SETTLE_W-1:0] settle_load;
    logic [CNT_W-1:0]    samp_cnt;
    logic [CNT_W-1:0]    tally;
    logic                sync_q1;
    logic                cmp_s;

    logic [NCH-1:0]      elig;
    logic [CH_W-1:0]     search_base;
    logic [SUM_W-1:0]    cand_sum;
    logic [CH_W-1:0]     cand;
    logic                found;
    logic [CH_W-1:0]     found_ch;

`ifdef AFE_CHAN_MASK_EN
    assign elig = chan_mask;
`else
    assign elig = '1;
`endif

    // NCH need not be a power of two, so the wrap is explicit.
    always_comb begin
        ch_inc = (ch == CH_W'(NCH - 1)) ? '0 : ch + CH_W'(1);
    end

    // A zero settle request still gives the analog side one cycle.
    always_comb begin
        settle_load = (settle_cycles == '0) ? SETTLE_W'(1) : settle_cycles;
    end

    // Round-robin search: the first eligible channel at or above the start
    // point, wrapping. From IDLE the start is ch_ptr; in NEXT, ch_ptr is only
    // being updated this cycle, so the search starts from ch+1 directly.
    always_comb begin
        search_base = (state == ST_NEXT) ? ch_inc : ch_ptr;
        found       = 1'b0;
        found_ch    = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int i = 0; i < NCH; i++) begin
            cand_sum = {1'b0, search_base} + SUM_W'(i);
            if (cand_sum >= SUM_W'(NCH)) begin
                cand_sum = cand_sum - SUM_W'(NCH);
            end
            cand = cand_sum[CH_W-1:0];
            if (!found && elig[cand]) begin
                found    = 1'b1;
                found_ch = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and outputs
    always_comb begin
        state_nx  = state;
        amp_en    = '0;
        busy      = 1'b1;
        res_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (scan_en && found) begin
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                amp_en = NCH'(1) << ch;
                if (settle_cnt == '0) begin
                    state_nx = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                amp_en = NCH'(1) << ch;
                if (samp_cnt == CNT_W'(NSAMP - 1)) begin
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                amp_en    = NCH'(1) << ch;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // amp_en stays low for this cycle so that two OTAs are never
                // driving the shared mux together.
                if (scan_en && found) begin
                    state_nx = ST_SETTLE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Datapath: synchronizer, channel pointer, settle/sample counters, tally
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1    <= 1'b0;
            cmp_s      <= 1'b0;
            ch         <= '0;
            ch_ptr     <= '0;
            settle_cnt <= '0;
            samp_cnt   <= '0;
            tally      <= '0;
        end else begin
            sync_q1 <= cmp_in;
            cmp_s   <= sync_q1;

            if (state == ST_NEXT) begin
                ch_ptr <= ch_inc;
            end

            // Channel and settle length are captured only on entry to SETTLE,
            // so changes to settle_cycles mid-channel wait for the next one.
            if ((state == ST_IDLE || state == ST_NEXT) && state_nx == ST_SETTLE) begin
                ch         <= found_ch;
                settle_cnt <= settle_load - SETTLE_W'(1);
            end

            if (state == ST_SETTLE) begin
                if (settle_cnt != '0) begin
                    settle_cnt <= settle_cnt - SETTLE_W'(1);
                end else begin
                    samp_cnt <= '0;
                    tally    <= '0;
                end
            end

            if (state == ST_SAMPLE) begin
                samp_cnt <= samp_cnt + CNT_W'(1);
                if (tally != CNT_W'(NSAMP)) begin
                    tally <= tally + CNT_W'(cmp_s);
                end
            end
        end
    end

    assign mux_sel   = ch;
    assign res_chan  = ch;
    assign res_count = tally;
    assign res_bit   = (tally > CNT_W'(NSAMP / 2));
    assign state_dbg = state;

endmodule

// File: tb/tb_afe_chan_sequencer.sv
// Bench for afe_chan_sequencer (NCH=4, NSAMP=5). A transaction-level model
// follows each channel visit: which channel must be chosen, when res_valid
// must rise, which comparator samples make up the tally, and what the idle /
// break-before-make cycles must look like. Directed tests then pin the model
// with hand-computed literal values.

module tb_afe_chan_sequencer;

  localparam int NCH      = 4;
  localparam int CH_W     = 2;
  localparam int SETTLE_W = 8;
  localparam int NSAMP    = 5;
  localparam int CNT_W    = 3;
  localparam int HMAX     = 8192;

  logic                clk = 1'b0;
  logic                rst;
  logic                scan_en;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                cmp_in;
  logic                res_ready;
  logic [NCH-1:0]      mask_v = '1;
  logic [NCH-1:0]      amp_en;
  logic [CH_W-1:0]     mux_sel;
  logic                busy;
  logic                res_valid;
  logic [CH_W-1:0]     res_chan;
  logic                res_bit;
  logic [CNT_W-1:0]    res_count;
  logic [2:0]          state_dbg;

  afe_chan_sequencer #(
    .NCH(NCH), .CH_W(CH_W), .SETTLE_W(SETTLE_W), .NSAMP(NSAMP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scan_en(scan_en),
    .settle_cycles(settle_cycles),
    .cmp_in(cmp_in),
`ifdef AFE_CHAN_MASK_EN
    .chan_mask(mask_v),
`endif
    .amp_en(amp_en),
    .mux_sel(mux_sel),
    .busy(busy),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_chan(res_chan),
    .res_bit(res_bit),
    .res_count(res_count),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int first_elig(input int from);
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (from + i) % NCH;
      if (mask_v[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- behavioural model + compare ----------------
  int hist[HMAX];
  int ph = 0;           // 0 idle, 1 channel in progress, 2 break cycle after transfer
  bit exp_rise = 1'b0;
  int m_ptr = 0;
  int m_ch, t0, s_cap, vt, e_cnt;

  int x_chan[$];
  int x_cnt[$];
  int x_bit[$];
  int x_cyc[$];
  int x_rise[$];
  int r_t0[$];

  always @(negedge clk) begin
    hist[cyc % HMAX] = cmp_in;
    if (rst) begin
      ph = 0;
      exp_rise = 1'b0;
      m_ptr = 0;
    end else begin
      if (ph == 2) begin
        chk("next_amp", amp_en, 0);
        chk("next_busy", busy, 1);
        chk("next_valid", res_valid, 0);
        exp_rise = scan_en && (first_elig(0) >= 0);
        ph = 0;
      end else if (ph == 0) begin
        if (exp_rise) begin
          chk("start_amp", amp_en != 0, 1);
          m_ch  = first_elig(m_ptr);
          t0    = cyc;
          s_cap = (settle_cycles == 0) ? 1 : int'(settle_cycles);
          vt    = t0 + s_cap + NSAMP;
          r_t0.push_back(cyc);
          exp_rise = 1'b0;
          ph = 1;
        end else begin
          chk("idle_amp", amp_en, 0);
          chk("idle_busy", busy, 0);
          chk("idle_valid", res_valid, 0);
          exp_rise = scan_en && (first_elig(0) >= 0);
        end
      end
      if (ph == 1) begin
        chk("chan_amp", amp_en, 32'(1) << m_ch);
        chk("chan_mux", mux_sel, m_ch);
        chk("chan_busy", busy, 1);
        if (cyc < vt) begin
          chk("valid_early", res_valid, 0);
        end else begin
          if (cyc == vt) begin
            // comparator value reaches the sampler two cycles after cmp_in
            e_cnt = 0;
            for (int j = 0; j < NSAMP; j++) e_cnt += hist[(t0 + s_cap - 2 + j) % HMAX];
            x_rise.push_back(cyc);
          end
          chk("valid_hold", res_valid, 1);
          chk("res_chan", res_chan, m_ch);
          chk("res_count", res_count, e_cnt);
          chk("res_bit", res_bit, (e_cnt > NSAMP / 2) ? 1 : 0);
          if (res_valid && res_ready) begin
            x_chan.push_back(res_chan);
            x_cnt.push_back(res_count);
            x_bit.push_back(res_bit);
            x_cyc.push_back(cyc);
            m_ptr = (m_ch + 1) % NCH;
            ph = 2;
          end
        end
      end
    end
  end

  // ---------------- driver / wait tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int k = 0;
    while (x_chan.size() < n && k < budget) begin
      @(negedge clk); #1; k++;
    end
    chk("wait_xfer", x_chan.size() >= n, 1);
  endtask

  task automatic wait_rise(input int n, input int budget);
    int k = 0;
    while (r_t0.size() < n && k < budget) begin
      @(negedge clk); #1; k++;
    end
    chk("wait_rise", r_t0.size() >= n, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(ph == 0 && busy == 1'b0) && k < budget) begin
      @(negedge clk); #1; k++;
    end
    chk("wait_idle", busy, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_amp_en"}, amp_en, 0);
    chk({tag, "_mux_sel"}, mux_sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_chan"}, res_chan, 0);
    chk({tag, "_res_bit"}, res_bit, 0);
    chk({tag, "_res_count"}, res_count, 0);
  endtask

  // ---------------- stimulus ----------------
  int exp_seq1[5] = '{0, 1, 2, 3, 0};
  int pat_maj[5]  = '{1, 0, 1, 0, 0};
  int n0, rel;

  initial begin
    rst = 1'b1; scan_en = 1'b0; settle_cycles = 8'd3; cmp_in = 1'b1; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk_reset_outputs("rst0");

    // Basic scan: settle 3, all ones, ready high.
    tick(); scan_en = 1'b1;
    wait_xfers(5, 300);
    scan_en = 1'b0;
    if (x_chan.size() >= 5 && x_rise.size() >= 5 && r_t0.size() >= 1) begin
      for (int i = 0; i < 5; i++) begin
        chk("scan_chan", x_chan[i], exp_seq1[i]);
        chk("scan_count", x_cnt[i], 5);
        chk("scan_bit", x_bit[i], 1);
      end
      for (int i = 0; i < 4; i++) chk("scan_period", x_rise[i+1] - x_rise[i], 10);
      chk("scan_latency", x_rise[0] - r_t0[0], 8);
    end
    wait_idle(60);

    // Reset in the middle of SAMPLE.
    tick(); scan_en = 1'b1;
    n0 = r_t0.size();
    wait_rise(n0 + 1, 50);
    repeat (4) tick();
    rst = 1'b1; scan_en = 1'b0;
    n0 = x_chan.size();
    tick(); rst = 1'b0;
    @(negedge clk); #1;
    chk_reset_outputs("rst_mid");
    chk("rst_mid_state", state_dbg, 0);
    repeat (10) begin @(negedge clk); #1; end
    chk("rst_mid_no_result", x_chan.size(), n0);

    // Majority vote: samples 1,0,1,0,0 on channel 0.
    cmp_in = 1'b0; settle_cycles = 8'd3;
    tick(); scan_en = 1'b1;
    n0 = r_t0.size();
    wait_rise(n0 + 1, 50);
    scan_en = 1'b0;
    for (int j = 0; j < 5; j++) begin tick(); cmp_in = pat_maj[j][0]; end
    tick(); cmp_in = 1'b0;
    n0 = x_chan.size();
    wait_xfers(n0 + 1, 50);
    if (x_chan.size() > n0) begin
      chk("maj_chan", x_chan[n0], 0);
      chk("maj_count", x_cnt[n0], 2);
      chk("maj_bit", x_bit[n0], 0);
    end
    wait_idle(20);

    // Backpressure on channel 1: ready low for 20 cycles in HOLD.
    cmp_in = 1'b1; settle_cycles = 8'd2; res_ready = 1'b0;
    repeat (3) tick();
    scan_en = 1'b1;
    n0 = x_chan.size();
    begin
      int k = 0;
      while (!res_valid && k < 50) begin @(negedge clk); #1; k++; end
      chk("bp_valid_seen", res_valid, 1);
    end
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    chk("bp_no_xfer", x_chan.size(), n0);
    chk("bp_valid", res_valid, 1);
    chk("bp_chan", res_chan, 1);
    chk("bp_count", res_count, 5);
    chk("bp_amp", amp_en, 4'b0010);
    tick(); res_ready = 1'b1; scan_en = 1'b0; rel = cyc;
    wait_xfers(n0 + 1, 20);
    if (x_chan.size() > n0) begin
      chk("bp_xfer_cycle", x_cyc[n0], rel);
      chk("bp_xfer_chan", x_chan[n0], 1);
    end
    wait_idle(20);

    // Scan stop during SETTLE of channel 2; settle change has no effect.
    settle_cycles = 8'd6;
    tick(); scan_en = 1'b1;
    n0 = r_t0.size();
    wait_rise(n0 + 1, 50);
    settle_cycles = 8'd0; scan_en = 1'b0;
    chk("stop_mux", mux_sel, 2);
    n0 = x_chan.size();
    wait_xfers(n0 + 1, 60);
    if (x_chan.size() > n0) begin
      chk("stop_chan", x_chan[n0], 2);
      chk("stop_latency", x_rise[x_rise.size()-1] - r_t0[r_t0.size()-1], 11);
    end
    repeat (3) begin @(negedge clk); #1; end
    chk("stop_busy", busy, 0);

    // Zero settle: one settle cycle on channel 3.
    tick(); scan_en = 1'b1;
    n0 = r_t0.size();
    wait_rise(n0 + 1, 50);
    scan_en = 1'b0;
    n0 = x_chan.size();
    wait_xfers(n0 + 1, 40);
    if (x_chan.size() > n0) begin
      chk("zs_chan", x_chan[n0], 3);
      chk("zs_count", x_cnt[n0], 5);
      chk("zs_latency", x_rise[x_rise.size()-1] - r_t0[r_t0.size()-1], 6);
    end
    wait_idle(20);

`ifdef AFE_CHAN_MASK_EN
    // Mask 1010: channels 1 and 3 only; then an empty mask never starts.
    settle_cycles = 8'd3;
    tick(); mask_v = 4'b1010; scan_en = 1'b1;
    n0 = x_chan.size();
    wait_xfers(n0 + 4, 200);
    scan_en = 1'b0;
    if (x_chan.size() >= n0 + 4) begin
      chk("mask_chan0", x_chan[n0], 1);
      chk("mask_chan1", x_chan[n0+1], 3);
      chk("mask_chan2", x_chan[n0+2], 1);
      chk("mask_chan3", x_chan[n0+3], 3);
    end
    wait_idle(40);
    tick(); mask_v = '0; scan_en = 1'b1;
    n0 = r_t0.size();
    repeat (20) begin @(negedge clk); #1; end
    chk("mask_zero_busy", busy, 0);
    chk("mask_zero_nostart", r_t0.size(), n0);
    scan_en = 1'b0;
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end before timeout", cyc);
    $fatal(1);
  end

endmodule
